collision_event_filter: RTL and testbench

//  Downstream of the per-pixel collision detector: accumulates per-zone collision pixel hits

---
 rtl/collision_event_filter.sv | 119 +++++++++++
 tb/tb_collision_event_filter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_event_filter.sv
// collision_event_filter: per-zone frame hit counting, threshold, confirmation and hold-off, with events issued one at a time over valid/ack.
// Optional COLLISION_STATS_EN adds event_count and last_cnt outputs.
module collision_event_filter #(
  parameter int NUM_ZONES       = 5,
  parameter int PIXEL_THRESHOLD = 50,
  parameter int CNT_W           = 12,
  parameter int CONFIRM_FRAMES  = 2,
  parameter int HOLDOFF_FRAMES  = 30,
  localparam int ZW   = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1,
  localparam int CF_W = $clog2(CONFIRM_FRAMES + 1),
  localparam int HO_W = (HOLDOFF_FRAMES > 0) ? $clog2(HOLDOFF_FRAMES + 1) : 1
) (
  input  logic                 clk_25MHz,
  input  logic                 reset,
  input  logic                 frame_start,
  input  logic                 frame_end,
  input  logic [NUM_ZONES-1:0] collision_hit,
  input  logic [NUM_ZONES-1:0] zone_en,
  output logic                 event_valid,
  output logic [ZW-1:0]        event_zone,
  input  logic                 event_ack
`ifdef COLLISION_STATS_EN
  ,
  output logic [15:0]          event_count,
  output logic [CNT_W-1:0]     last_cnt
`endif
);
  typedef enum logic {IDLE, SHOW} state_t;
  state_t               state_q, state_d;
  logic [ZW-1:0]        zone_q, zone_d, sel;
  logic [NUM_ZONES-1:0] pend_q, pend_d, hit;
  logic [CNT_W-1:0]     cnt_q [NUM_ZONES];
  logic [CNT_W-1:0]     cnt_d [NUM_ZONES];
  logic [CNT_W-1:0]     cnt_inc [NUM_ZONES];
  logic [CF_W-1:0]      conf_q [NUM_ZONES];
  logic [CF_W-1:0]      conf_d [NUM_ZONES];
  logic [HO_W-1:0]      hold_q [NUM_ZONES];
  logic [HO_W-1:0]      hold_d [NUM_ZONES];
  always_comb begin
    hit = '0;
    for (int z = 0; z < NUM_ZONES; z++) begin
      cnt_inc[z] = (collision_hit[z] && zone_en[z] && cnt_q[z] != '1) ? cnt_q[z] + 1'b1 : cnt_q[z];
      hit[z] = cnt_inc[z] >= CNT_W'(PIXEL_THRESHOLD);
    end
  end
  always_comb begin
    sel = '0;
    for (int z = NUM_ZONES - 1; z >= 0; z--)
      if (pend_q[z]) sel = ZW'(z);
  end
  always_comb begin
    state_d = state_q;
    zone_d  = zone_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    conf_d  = conf_q;
    hold_d  = hold_q;
    if (state_q == IDLE && |pend_q) begin
      state_d     = SHOW;
      zone_d      = sel;
      pend_d[sel] = 1'b0;
    end else if (state_q == SHOW && event_ack) begin
      state_d = IDLE;
    end
    for (int z = 0; z < NUM_ZONES; z++) begin
      if (frame_end) begin
        // a completed confirmation run always restarts, so a blocked zone must re-confirm
        if (hit[z] && conf_q[z] == CF_W'(CONFIRM_FRAMES - 1)) begin
          conf_d[z] = '0;
          if (hold_q[z] == '0 && !pend_q[z] && !(state_q == SHOW && zone_q == ZW'(z))) pend_d[z] = 1'b1;
        end else begin
          conf_d[z] = hit[z] ? conf_q[z] + 1'b1 : '0;
        end
        hold_d[z] = (hold_q[z] != '0) ? hold_q[z] - 1'b1 : hold_q[z];
      end
      cnt_d[z] = frame_start ? CNT_W'(collision_hit[z] && zone_en[z]) : cnt_inc[z];
      if (!zone_en[z]) begin
        cnt_d[z]  = '0;
        conf_d[z] = '0;
        pend_d[z] = 1'b0;
      end
    end
    if (state_q == SHOW && event_ack) hold_d[zone_q] = HO_W'(HOLDOFF_FRAMES);
  end
  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      state_q <= IDLE;
      zone_q  <= '0;
      pend_q  <= '0;
      cnt_q   <= '{default: '0};
      conf_q  <= '{default: '0};
      hold_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      zone_q  <= zone_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      conf_q  <= conf_d;
      hold_q  <= hold_d;
    end
  end
  assign event_valid = state_q == SHOW;
  assign event_zone  = zone_q;
`ifdef COLLISION_STATS_EN
  logic [15:0]      event_count_q;
  logic [CNT_W-1:0] last_cnt_q;
  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      event_count_q <= '0;
      last_cnt_q    <= '0;
    end else begin
      if (frame_end) last_cnt_q <= cnt_inc[0];
      if (state_q == SHOW && event_ack && event_count_q != 16'hFFFF) event_count_q <= event_count_q + 16'd1;
    end
  end
  assign event_count = event_count_q;
  assign last_cnt    = last_cnt_q;
`endif
endmodule

// File: tb/tb_collision_event_filter.sv
// tb_collision_event_filter: drives frames of collision hits against a frame-rule reference model.
module tb_collision_event_filter;
  logic       clk = 1'b0;
  logic       reset = 1'b1, frame_start = 1'b0, frame_end = 1'b0, event_ack = 1'b0;
  logic [4:0] collision_hit = '0, zone_en = '1;
  logic       event_valid;
  logic [2:0] event_zone;
`ifdef COLLISION_STATS_EN
  logic [15:0] event_count;
  logic [11:0] last_cnt;
`endif
  int passed = 0, total = 0;
  int m_cnt [5], m_conf [5], m_hold [5];
  bit m_pend [5];
  bit m_show;
  int m_zone;
  int mism;
  bit seen;
  int fn [5];

  collision_event_filter dut (
    .clk_25MHz(clk), .reset(reset), .frame_start(frame_start), .frame_end(frame_end),
    .collision_hit(collision_hit), .zone_en(zone_en), .event_valid(event_valid),
    .event_zone(event_zone), .event_ack(event_ack)
`ifdef COLLISION_STATS_EN
    , .event_count(event_count), .last_cnt(last_cnt)
`endif
  );

  always #20 clk = ~clk;

  function automatic int mn(int a, int b);
    return a < b ? a : b;
  endfunction

  function automatic void model(bit rst, bit fs, bit fe, logic [4:0] h, logic [4:0] e, bit a);
    int sel = -1;
    int inc, nc;
    bit np [5];
    if (rst) begin
      for (int z = 0; z < 5; z++) begin m_cnt[z] = 0; m_conf[z] = 0; m_hold[z] = 0; m_pend[z] = 0; end
      m_show = 0;
      m_zone = 0;
      return;
    end
    if (!m_show) for (int z = 4; z >= 0; z--) if (m_pend[z]) sel = z;
    for (int z = 0; z < 5; z++) begin
      np[z] = m_pend[z] && z != sel;
      inc = (h[z] && e[z]) ? mn(m_cnt[z] + 1, 4095) : m_cnt[z];
      if (fe) begin
        nc = (inc >= 50) ? m_conf[z] + 1 : 0;
        if (nc >= 2) begin
          nc = 0;
          if (m_hold[z] == 0 && !m_pend[z] && !(m_show && m_zone == z)) np[z] = 1;
        end
        m_conf[z] = nc;
        if (m_hold[z] > 0) m_hold[z]--;
      end
      m_cnt[z] = fs ? int'(h[z] && e[z]) : inc;
      if (!e[z]) begin m_cnt[z] = 0; m_conf[z] = 0; np[z] = 0; end
    end
    if (m_show && a) begin
      m_show = 0;
      m_hold[m_zone] = 30;
    end else if (sel >= 0) begin
      m_show = 1;
      m_zone = sel;
    end
    for (int z = 0; z < 5; z++) m_pend[z] = np[z];
  endfunction

  task automatic cyc(input bit rst, input bit fs, input bit fe, input logic [4:0] h, input logic [4:0] e, input bit a);
    @(negedge clk);
    reset = rst; frame_start = fs; frame_end = fe; collision_hit = h; zone_en = e; event_ack = a;
    model(rst, fs, fe, h, e, a);
    @(posedge clk);
    #1;
    if (event_valid !== m_show || event_zone !== 3'(m_zone)) mism++;
    if (event_valid === 1'b1) seen = 1;
  endtask

  task automatic idle(input logic [4:0] e, input bit a);
    cyc(0, 0, 0, 5'h0, e, a);
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 5'h0, 5'h1f, 0);
    mism = 0;
    seen = 0;
    for (int z = 0; z < 5; z++) fn[z] = 0;
  endtask

  task automatic frame(input int len, input logic [4:0] e, input int ackp, input bit fs_first, input logic [4:0] fe_h, input bit fe_fs);
    logic [4:0] h;
    for (int i = 0; i < len; i++) begin
      for (int z = 0; z < 5; z++) h[z] = i < fn[z];
      cyc(0, fs_first && i == 0, 0, h, e, $urandom_range(0, 99) < ackp);
    end
    cyc(0, fe_fs, 1, fe_h, e, $urandom_range(0, 99) < ackp);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (event_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", event_valid); else passed++;
    total++; if (event_zone !== 3'd0) $display("FAIL reset_zone got=%0d exp=0", event_zone); else passed++;
  endtask

  task automatic test_basic();
    do_reset();
    fn[1] = 60;
    repeat (2) frame(70, 5'h1f, 0, 1, 5'h0, 0);
    total++; if (event_valid !== 1'b0) $display("FAIL basic_lat1 got=%b exp=0", event_valid); else passed++;
    idle(5'h1f, 0);
    total++; if (event_valid !== 1'b1 || event_zone !== 3'd1) $display("FAIL basic_lat2 got=%b/%0d exp=1/1", event_valid, event_zone); else passed++;
    idle(5'h1f, 1);
    total++; if (event_valid !== 1'b0) $display("FAIL basic_ack got=%b exp=0", event_valid); else passed++;
    idle(5'h1f, 0);
    total++; if (event_valid !== 1'b0) $display("FAIL basic_after got=%b exp=0", event_valid); else passed++;
    total++; if (mism !== 0) $display("FAIL basic_model got=%0d exp=0 mismatching cycles", mism); else passed++;
  endtask

  task automatic test_threshold();
    do_reset();
    fn[1] = 49;
    repeat (5) frame(70, 5'h1f, 0, 1, 5'h0, 0);
    repeat (2) idle(5'h1f, 0);
    total++; if (seen !== 1'b0) $display("FAIL thr49_never got=%b exp=0", seen); else passed++;
    fn[1] = 50;
    repeat (2) frame(70, 5'h1f, 0, 1, 5'h0, 0);
    idle(5'h1f, 0);
    total++; if (event_valid !== 1'b1 || event_zone !== 3'd1) $display("FAIL thr50 got=%b/%0d exp=1/1", event_valid, event_zone); else passed++;
    total++; if (mism !== 0) $display("FAIL thr_model got=%0d exp=0 mismatching cycles", mism); else passed++;
  endtask

  task automatic test_priority();
    do_reset();
    fn[0] = 60; fn[3] = 60;
    repeat (2) frame(70, 5'h1f, 0, 1, 5'h0, 0);
    idle(5'h1f, 0);
    total++; if (event_valid !== 1'b1 || event_zone !== 3'd0) $display("FAIL prio_first got=%b/%0d exp=1/0", event_valid, event_zone); else passed++;
    idle(5'h1f, 1);
    total++; if (event_valid !== 1'b0) $display("FAIL prio_gap got=%b exp=0", event_valid); else passed++;
    idle(5'h1f, 0);
    total++; if (event_valid !== 1'b1 || event_zone !== 3'd3) $display("FAIL prio_second got=%b/%0d exp=1/3", event_valid, event_zone); else passed++;
    idle(5'h1f, 1);
    total++; if (mism !== 0) $display("FAIL prio_model got=%0d exp=0 mismatching cycles", mism); else passed++;
  endtask

  task automatic test_holdoff();
    int first = 0;
    do_reset();
    fn[2] = 60;
    repeat (2) frame(70, 5'h1f, 0, 1, 5'h0, 0);
    idle(5'h1f, 0);
    total++; if (event_valid !== 1'b1 || event_zone !== 3'd2) $display("FAIL hold_first got=%b/%0d exp=1/2", event_valid, event_zone); else passed++;
    idle(5'h1f, 1);
    for (int j = 1; j <= 34; j++) begin
      frame(70, 5'h1f, 0, 1, 5'h0, 0);
      idle(5'h1f, 0);
      if (event_valid === 1'b1 && first == 0) first = j;
      if (event_valid === 1'b1) idle(5'h1f, 1);
    end
    total++; if (first !== 32) $display("FAIL hold_next_frame got=%0d exp=32", first); else passed++;
    total++; if (mism !== 0) $display("FAIL hold_model got=%0d exp=0 mismatching cycles", mism); else passed++;
  endtask

  task automatic test_enable();
    do_reset();
    fn[1] = 60;
    repeat (2) frame(70, 5'h1f, 0, 1, 5'h0, 0);
    idle(5'h1f, 0);
    total++; if (event_valid !== 1'b1 || event_zone !== 3'd1) $display("FAIL en_event got=%b/%0d exp=1/1", event_valid, event_zone); else passed++;
    repeat (3) frame(70, 5'h1d, 0, 1, 5'h0, 0);
    total++; if (event_valid !== 1'b1 || event_zone !== 3'd1) $display("FAIL en_held got=%b/%0d exp=1/1", event_valid, event_zone); else passed++;
    idle(5'h1d, 1);
    total++; if (event_valid !== 1'b0) $display("FAIL en_ack got=%b exp=0", event_valid); else passed++;
    seen = 0;
    repeat (3) frame(70, 5'h1d, 0, 1, 5'h0, 0);
    repeat (2) idle(5'h1d, 0);
    total++; if (seen !== 1'b0) $display("FAIL en_disabled got=%b exp=0", seen); else passed++;
    total++; if (mism !== 0) $display("FAIL en_model got=%0d exp=0 mismatching cycles", mism); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    fn[4] = 60;
    repeat (2) frame(70, 5'h1f, 0, 1, 5'h0, 0);
    idle(5'h1f, 0);
    total++; if (event_valid !== 1'b1 || event_zone !== 3'd4) $display("FAIL rst_mid_event got=%b/%0d exp=1/4", event_valid, event_zone); else passed++;
    cyc(1, 0, 0, 5'h0, 5'h1f, 0);
    total++; if (event_valid !== 1'b0 || event_zone !== 3'd0) $display("FAIL rst_mid_clear got=%b/%0d exp=0/0", event_valid, event_zone); else passed++;
    seen = 0;
    repeat (3) idle(5'h1f, 0);
    total++; if (seen !== 1'b0) $display("FAIL rst_mid_dropped got=%b exp=0", seen); else passed++;
    fn[4] = 0; fn[0] = 4145;
    repeat (2) frame(4145, 5'h1f, 0, 1, 5'h0, 0);
    idle(5'h1f, 0);
    total++; if (event_valid !== 1'b1 || event_zone !== 3'd0) $display("FAIL sat_event got=%b/%0d exp=1/0", event_valid, event_zone); else passed++;
    total++; if (mism !== 0) $display("FAIL sat_model got=%0d exp=0 mismatching cycles", mism); else passed++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    fn[1] = 60; fn[3] = 60;
    frame(70, 5'h1f, 0, 1, 5'b01010, 1);
    fn[1] = 48; fn[3] = 49;
    frame(70, 5'h1f, 0, 0, 5'h0, 0);
    idle(5'h1f, 0);
    total++; if (event_valid !== 1'b1 || event_zone !== 3'd3) $display("FAIL simul_event got=%b/%0d exp=1/3", event_valid, event_zone); else passed++;
    idle(5'h1f, 1);
    seen = 0;
    repeat (3) idle(5'h1f, 0);
    total++; if (seen !== 1'b0) $display("FAIL simul_no_zone1 got=%b exp=0", seen); else passed++;
    total++; if (mism !== 0) $display("FAIL simul_model got=%0d exp=0 mismatching cycles", mism); else passed++;
  endtask

  task automatic test_random();
    logic [4:0] e;
    do_reset();
    repeat (20) begin
      for (int z = 0; z < 5; z++) begin
        fn[z] = $urandom_range(30, 70);
        e[z] = $urandom_range(0, 9) != 0;
      end
      frame(72, e, 15, 1, 5'($urandom_range(0, 31)), $urandom_range(0, 3) == 0);
    end
    repeat (4) idle(5'h1f, 1);
    total++; if (mism !== 0) $display("FAIL random_model got=%0d exp=0 mismatching cycles", mism); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_threshold();
    test_priority();
    test_holdoff();
    test_enable();
    test_reset_mid();
    test_simultaneous();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
